fpu_mult_result_queue: RTL
==========================

Name: fpu_mult_result_queue

Overview:
- Capture stage directly downstream of the single-precision combinational multiplier.
- Samples the multiplier result on each operation strobe and tags unrepresentable results with an exception bit (multiplier valid low).
- Buffers tagged results in a first-word-fall-through FIFO with a valid/ready handshake to the consumer (writeback/bus).
- Keeps saturating result and exception counters plus a sticky overflow error.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >= 2.
- CNT_W, 16: width of the result and exception counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- op_strobe  input  1  operation issued this cycle; the same signal drives the multiplier's input-valid.
- mult_data  input  32  multiplier result {sign, exp[7:0], mant[22:0]}.
- mult_valid  input  1  multiplier result-representable flag.
- out_ready  input  1  consumer accepts head entry.
- clr_err  input  1  synchronous clear of overflow_err.
- out_valid  output  1  head entry present.
- out_data  output  32  head entry result.
- out_exc  output  1  head entry exception tag (1 = multiplier reported not representable).
- level  output  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
- fifo_full  output  1  level == DEPTH.
- overflow_err  output  1  sticky; a strobe was dropped.
- result_cnt  output  CNT_W  accepted entries since reset, saturating.
- exc_cnt  output  CNT_W  accepted entries with exc = 1 since reset, saturating.

Behaviour:
- Reset values (asynchronous, immediate):
  - level = 0, out_valid = 0, fifo_full = 0.
  - overflow_err = 0, result_cnt = 0, exc_cnt = 0.
  - Read and write pointers = 0; out_data/out_exc = 0.
  - Storage contents need not be cleared.
- Entry format: 33 bits, {exc, data}.
  - exc = ~mult_valid.
  - data = mult_data unmodified, including when exc = 1.
- Push:
  - A push occurs at a clk edge where op_strobe = 1 and (level < DEPTH, or a pop occurs on the same edge).
  - Write pointer increments modulo DEPTH; wrap-around is a natural pointer wrap.
- Pop:
  - A pop occurs at a clk edge where out_valid = 1 and out_ready = 1.
  - Read pointer increments modulo DEPTH.
- Latency:
  - An entry pushed at edge N is visible on out_data/out_exc with out_valid = 1 after edge N (1 cycle).
  - out_data/out_exc are driven combinationally from the read pointer.
- out_valid = (level != 0).
  - out_data/out_exc hold the head entry until it is popped.
  - They are don't-care when out_valid = 0.
- level update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop on the same edge: unchanged.
  - Neither: unchanged.
- Full and strobed with no pop:
  - The entry is dropped.
  - overflow_err sets at that edge; level, pointers and counters are unchanged.
- Empty with out_ready = 1: no pop; nothing changes.
  - Push into an empty FIFO is never bypassed to the output in the same cycle.
- Counters:
  - result_cnt += 1 on every push.
  - exc_cnt += 1 on every push with exc = 1.
  - Both saturate at 2^CNT_W - 1 and never wrap.
- overflow_err:
  - Set has priority over clr_err when both occur on the same edge.
  - Otherwise clr_err = 1 clears it at the edge.
- No state machine beyond the pointers/level; all state updates on the rising edge of clk except rst.
- Reset mid-stream:
  - All buffered entries are discarded.
  - Outputs go to reset values without waiting for a clock edge.
  - A strobe coincident with rst deassertion is accepted on the first edge where rst = 0.

Test Plan:
- Single result: mult_data = 0x40C00000 (2.0 x 3.0), mult_valid = 1, one-cycle op_strobe, out_ready = 0 -> the next cycle shows out_valid = 1, out_data = 0x40C00000, out_exc = 0, level = 1, result_cnt = 1, exc_cnt = 0.
- Exception tag: mult_data = 0x7F800000, mult_valid = 0, op_strobe -> out_exc = 1, out_data = 0x7F800000, exc_cnt = 1.
- Ordering and wrap-around:
  - Push 0x3F800000, 0x40000000, 0x40400000, 0x40800000 with out_ready = 0 -> fifo_full = 1.
  - Then out_ready = 1 for 4 cycles -> pops in that order, level 3, 2, 1, 0.
  - Then 6 more pushes and pops wrap the pointers with order preserved.
- Overflow:
  - With level = 4 and out_ready = 0, strobe 0x41000000 -> dropped, overflow_err = 1, level = 4, result_cnt unchanged.
  - A 5th strobe with clr_err = 1 on the same edge -> overflow_err stays 1.
  - clr_err alone -> overflow_err = 0.
- Simultaneous push/pop at full: level = 4, out_ready = 1, strobe 0x41200000 -> level stays 4, the head advances, 0x41200000 becomes the tail, overflow_err stays 0.
- Reset and saturation:
  - Assert rst between edges with level = 3 -> out_valid = 0, level = 0, counters 0 immediately.
  - With CNT_W = 4, 20 accepted pushes (draining concurrently) -> result_cnt = 15.

Source files
------------

// File: rtl/fpu_mult_result_queue.sv
// Purpose : captures single-precision multiplier results, tags unrepresentable ones, queues them FWFT.
// Latency : 1 cycle from op_strobe edge to out_valid/out_data; head driven combinationally from read pointer.
// Backpressure: out_valid/out_ready handshake; strobe while full with no pop is dropped and sets overflow_err.
//
// Ports:
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   op_strobe              operation issued (same signal as multiplier input-valid)
//   mult_data, mult_valid  multiplier result and its representable flag
//   out_ready              consumer accepts head entry
//   clr_err                synchronous clear of overflow_err
//   out_valid/out_data/out_exc   head entry and its exception tag
//   level, fifo_full       occupancy
//   overflow_err           sticky dropped-strobe flag
//   result_cnt, exc_cnt    saturating accepted / accepted-with-exception counters
module fpu_mult_result_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_strobe,
    input  logic [31:0]                mult_data,
    input  logic                       mult_valid,
    input  logic                       out_ready,
    input  logic                       clr_err,
    output logic                       out_valid,
    output logic [31:0]                out_data,
    output logic                       out_exc,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       fifo_full,
    output logic                       overflow_err,
    output logic [CNT_W-1:0]           result_cnt,
    output logic [CNT_W-1:0]           exc_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Entry layout: {exc, data}
    logic [32:0]      mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] result_cnt_q, result_cnt_d;
    logic [CNT_W-1:0] exc_cnt_q, exc_cnt_d;

    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             drop;
    logic             new_exc;

    assign full    = (level_q == LVL_FULL);
    assign empty   = (level_q == '0);
    assign new_exc = ~mult_valid;

    assign pop  = ~empty & out_ready;
    // A pop on the same edge frees the slot, so a full queue can still accept.
    assign push = op_strobe & (~full | pop);
    assign drop = op_strobe & full & ~pop;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        result_cnt_d = result_cnt_q;
        exc_cnt_d    = exc_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LVL_ONE;
        end

        if (push && result_cnt_q != CNT_MAX) begin
            result_cnt_d = result_cnt_q + CNT_ONE;
        end
        if (push && new_exc && exc_cnt_q != CNT_MAX) begin
            exc_cnt_d = exc_cnt_q + CNT_ONE;
        end

        // A new drop wins over a clear on the same edge.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            result_cnt_q <= '0;
            exc_cnt_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            result_cnt_q <= result_cnt_d;
            exc_cnt_q    <= exc_cnt_d;
        end
    end

    // Storage is not reset; its contents are only observed through out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {new_exc, mult_data};
        end
    end

    logic [32:0] head;
    assign head = mem_q[rd_ptr_q];

    // Gate the head so outputs read as zero whenever the queue is empty (incl. reset).
    assign out_valid    = ~empty;
    assign out_data     = empty ? 32'h0 : head[31:0];
    assign out_exc      = empty ? 1'b0  : head[32];
    assign level        = level_q;
    assign fifo_full    = full;
    assign overflow_err = overflow_q;
    assign result_cnt   = result_cnt_q;
    assign exc_cnt      = exc_cnt_q;

endmodule
